// File: rtl/readout_rx_trial_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : readout_rx_trial_sequencer
// Brief    : Multi-round adaptive readout sequencer feeding the state-decision
//            logic with cumulative bin counts and per-round threshold addresses.
// Revision : 1.0 - initial release
// ============================================================================
module readout_rx_trial_sequencer #(
   parameter int BIN_COUNTER_WIDTH           = 16,
   parameter int THRESHOLD_MEMORY_ADDR_WIDTH = 4,
   parameter int ROUND_LEN_WIDTH             = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start_in,
   input  logic                                   abort_in,
   input  logic [ROUND_LEN_WIDTH-1:0]             round_len_in,
   input  logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] num_round_in,
   input  logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] threshold_base_addr_in,
   input  logic                                   sample_valid_in,
   input  logic                                   sample_state_in,
   input  logic                                   decision_fin_in,
   output logic [BIN_COUNTER_WIDTH-1:0]           bin_count_out,
   output logic                                   finish_trial_out,
   output logic                                   last_trial_out,
   output logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] threshold_addr_out,
   output logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] round_idx_out,
   output logic                                   busy_out,
   output logic                                   done_out,
   output logic                                   drop_err_out
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_DECIDE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [BIN_COUNTER_WIDTH-1:0]           c_bin_max   = '1;
   localparam logic [ROUND_LEN_WIDTH-1:0]             c_len_one   = ROUND_LEN_WIDTH'(1);
   localparam logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] c_round_one = THRESHOLD_MEMORY_ADDR_WIDTH'(1);

   state_t                                 r_state;
   state_t                                 w_next_state;
   logic [ROUND_LEN_WIDTH-1:0]             r_round_len;
   logic [ROUND_LEN_WIDTH-1:0]             r_sample_cnt;
   logic [ROUND_LEN_WIDTH-1:0]             w_sample_inc;
   logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] r_num_round;
   logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] r_base;
   logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] r_round_idx;
   logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] r_thr_addr;
   logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] w_round_inc;
   logic [BIN_COUNTER_WIDTH-1:0]           r_bin_cnt;
   logic                                   r_drop_err;
   logic                                   w_is_last;
   logic                                   w_advance;

   assign w_sample_inc = r_sample_cnt + c_len_one;
   assign w_round_inc  = r_round_idx + c_round_one;
   assign w_is_last    = (r_round_idx == (r_num_round - c_round_one));
   // A last round always terminates, even if the decision logic did not answer.
   assign w_advance    = !abort_in && !decision_fin_in && !w_is_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (start_in) w_next_state = S_ACCUM;
         S_ACCUM:  if (sample_valid_in && (w_sample_inc == r_round_len)) w_next_state = S_DECIDE;
         S_DECIDE: w_next_state = (decision_fin_in || w_is_last) ? S_DONE : S_ACCUM;
         S_DONE:   w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
      if (abort_in && (r_state != S_IDLE)) begin
         w_next_state = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_round_len  <= '0;
         r_sample_cnt <= '0;
         r_num_round  <= '0;
         r_base       <= '0;
         r_round_idx  <= '0;
         r_thr_addr   <= '0;
         r_bin_cnt    <= '0;
         r_drop_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_in) begin
                  r_round_len  <= (round_len_in == '0) ? c_len_one : round_len_in;
                  r_num_round  <= (num_round_in == '0) ? c_round_one : num_round_in;
                  r_base       <= threshold_base_addr_in;
                  r_thr_addr   <= threshold_base_addr_in;
                  r_sample_cnt <= '0;
                  r_bin_cnt    <= '0;
                  r_round_idx  <= '0;
                  r_drop_err   <= 1'b0;
               end
            end
            S_ACCUM: begin
               if (!abort_in && sample_valid_in) begin
                  r_sample_cnt <= w_sample_inc;
                  if (sample_state_in && (r_bin_cnt != c_bin_max)) begin
                     r_bin_cnt <= r_bin_cnt + 1'b1;
                  end
               end
            end
            S_DECIDE: begin
               // Bin count deliberately carries over into the next round.
               if (w_advance) begin
                  r_round_idx  <= w_round_inc;
                  r_thr_addr   <= r_base + w_round_inc;
                  r_sample_cnt <= '0;
               end
            end
            default: begin
            end
         endcase
         if (sample_valid_in && ((r_state == S_DECIDE) || (r_state == S_DONE))) begin
            r_drop_err <= 1'b1;
         end
      end
   end

   assign bin_count_out      = r_bin_cnt;
   assign threshold_addr_out = r_thr_addr;
   assign round_idx_out      = r_round_idx;
   assign drop_err_out       = r_drop_err;
   assign busy_out           = (r_state != S_IDLE);
   assign finish_trial_out   = (r_state == S_DECIDE);
   assign last_trial_out     = (r_state == S_DECIDE) && w_is_last;
   assign done_out           = (r_state == S_DONE);

endmodule
`default_nettype wire
